// File: rtl/Cipher_defs.sv
// Shared AES cipher datapath types, the reduction constant and the xtime helper.
package Cipher_defs;
  typedef logic [7:0]    t_byte;
  typedef t_byte [3:0]   t_column;
  typedef t_byte [15:0]  t_state;

  localparam t_byte AES_POLY = 8'h1B;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic t_byte xtime(input t_byte b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/mix_column.sv
// Combinational single-column MixColumns / InvMixColumns unit built from xtime chains.
module mix_column
  import Cipher_defs::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);
  // Packed index 3 holds row 0 (the MSB byte); rows rotate downward in index.
  t_column a, x2, x4, x8, y;

  assign a       = col_in;
  assign col_out = y;

  always_comb begin
    x2 = '0;
    x4 = '0;
    x8 = '0;
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
  end

  always_comb begin
    logic [1:0] k0, k1, k2, k3;
    y = '0;
    for (int r = 0; r < 4; r++) begin
      k0 = 2'(3 - r);
      k1 = k0 - 2'd1;
      k2 = k0 - 2'd2;
      k3 = k0 - 2'd3;
      if (INV_EN && inv)
        // E*a0 ^ B*a1 ^ D*a2 ^ 9*a3
        y[k0] = (x8[k0] ^ x4[k0] ^ x2[k0]) ^ (x8[k1] ^ x2[k1] ^ a[k1])
              ^ (x8[k2] ^ x4[k2] ^ a[k2])  ^ (x8[k3] ^ a[k3]);
      else
        y[k0] = x2[k0] ^ (x2[k1] ^ a[k1]) ^ a[k2] ^ a[k3];
    end
  end
endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES (Inv)MixColumns: one shared column unit applied to columns 0..3 on successive clocks.
module mix_columns_seq
  import Cipher_defs::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} t_fsm;

  t_fsm          state_q, state_d;
  logic [1:0]    col_q;
  logic          inv_q;
  t_column [3:0] buf_q;   // index 3 = column 0 (bytes s0..s3)
  logic [31:0]   mix_out;

  mix_column #(.INV_EN(INV_EN)) u_mix (
    .col_in  (buf_q[~col_q]),
    .inv     (inv_q),
    .col_out (mix_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (col_q == 2'd3) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      inv_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          buf_q <= in_state;
          inv_q <= INV_EN ? inv : 1'b0;
          col_q <= 2'd0;
        end
        // col wraps to 0 on the last column; IDLE reloads it anyway.
        BUSY: begin
          buf_q[~col_q] <= mix_out;
          col_q         <= col_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign out_state = buf_q;
endmodule
